// File: rtl/ens_vote_acc_pkg.sv
// ens_vote_acc_pkg
// Purpose : shared definitions for the ensemble vote accumulator.
//           - ens_state_e : ACC (collect member beats), SCAN (argmax walk),
//                           OUT (hold result until downstream takes it)
//           - sum_w()     : accumulator width able to hold num_ens maximal
//                           scores without overflow
package ens_vote_acc_pkg;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } ens_state_e;

    // Adding num_ens values of score_w bits needs $clog2(num_ens) extra bits.
    function automatic int sum_w(input int score_w, input int num_ens);
        return score_w + $clog2(num_ens);
    endfunction

endpackage

// File: rtl/ens_vote_acc_if.sv
// ens_vote_acc_if
// Purpose : bundles the score-input and result-output handshakes of
//           ens_vote_acc.
// Signals : s_valid/s_ready/s_data   member score vector stream
//           m_valid/m_ready          result handshake
//           m_class/m_score          winning class index and its total
// Modports: master - the side that feeds scores and consumes results
//           slave  - the accumulator itself
interface ens_vote_acc_if
    import ens_vote_acc_pkg::*;
#(
    parameter int NUM_ENS     = 4,
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 4,
    localparam int SUM_W      = sum_w(SCORE_W, NUM_ENS),
    localparam int CLS_W      = $clog2(NUM_CLASSES)
) ();

    logic                           s_valid;
    logic                           s_ready;
    logic [NUM_CLASSES*SCORE_W-1:0] s_data;
    logic                           m_valid;
    logic                           m_ready;
    logic [CLS_W-1:0]               m_class;
    logic [SUM_W-1:0]               m_score;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_class, m_score
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_class, m_score
    );

endinterface

// File: rtl/ens_class_acc_bank.sv
// ens_class_acc_bank
// Purpose : one accumulator per class. Each add pulse adds the matching
//           zero-extended score field of data_i into every accumulator.
// Ports   : clk, rst     clock and synchronous active-high reset
//           clr_i        clear all accumulators (wins over add_i)
//           add_i        accumulate data_i this cycle
//           data_i       class k score in bits [k*SCORE_W +: SCORE_W]
//           rd_idx_i     class to read
//           rd_data_o    current total of class rd_idx_i (combinational)
module ens_class_acc_bank
    import ens_vote_acc_pkg::*;
#(
    parameter int NUM_ENS     = 4,
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 4,
    localparam int SUM_W      = sum_w(SCORE_W, NUM_ENS),
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr_i,
    input  logic                           add_i,
    input  logic [NUM_CLASSES*SCORE_W-1:0] data_i,
    input  logic [IDX_W-1:0]               rd_idx_i,
    output logic [SUM_W-1:0]               rd_data_o
);

    logic [NUM_CLASSES*SUM_W-1:0] acc_flat;

    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_acc
        logic [SUM_W-1:0] acc_q;
        logic [SUM_W-1:0] acc_d;

        // SUM_W is wide enough for NUM_ENS maximal scores, so no wrap check.
        assign acc_d = acc_q + SUM_W'(data_i[gi*SCORE_W +: SCORE_W]);

        always_ff @(posedge clk) begin
            if (rst || clr_i) begin
                acc_q <= '0;
            end else if (add_i) begin
                acc_q <= acc_d;
            end
        end

        assign acc_flat[gi*SUM_W +: SUM_W] = acc_q;
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (rd_idx_i == IDX_W'(k)) begin
                rd_data_o = acc_flat[k*SUM_W +: SUM_W];
            end
        end
    end

endmodule

// File: rtl/ens_vote_acc.sv
// ens_vote_acc
// Purpose : sums NUM_ENS member score vectors per class, then walks the
//           classes one per cycle to find the argmax (lowest index on ties)
//           and presents it until the downstream accepts it.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           s_valid/s_ready/s_data   member score vector input
//           m_valid/m_ready          result handshake
//           m_class/m_score          winning class and its accumulated score
module ens_vote_acc
    import ens_vote_acc_pkg::*;
#(
    parameter int NUM_ENS     = 4,
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 4,
    localparam int SUM_W      = sum_w(SCORE_W, NUM_ENS),
    localparam int CLS_W      = $clog2(NUM_CLASSES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [NUM_CLASSES*SCORE_W-1:0] s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [CLS_W-1:0]               m_class,
    output logic [SUM_W-1:0]               m_score
);

    localparam int CNT_W = $clog2(NUM_ENS);
    localparam logic [CNT_W-1:0] LAST_MEMBER = CNT_W'(NUM_ENS - 1);
    localparam logic [CLS_W-1:0] LAST_CLASS  = CLS_W'(NUM_CLASSES - 1);

    ens_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CLS_W-1:0] scan_idx_q, scan_idx_d;
    logic [CLS_W-1:0] best_idx_q, best_idx_d;
    logic [SUM_W-1:0] best_score_q, best_score_d;
    logic [SUM_W-1:0] rd_data;
    logic             beat_take;
    logic             out_take;

    assign s_ready   = (state_q == ACC);
    assign m_valid   = (state_q == OUT);
    assign beat_take = s_valid && s_ready;
    assign out_take  = m_valid && m_ready;
    assign m_class   = best_idx_q;
    assign m_score   = best_score_q;

    ens_class_acc_bank #(
        .NUM_ENS     (NUM_ENS),
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_W     (SCORE_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (out_take),
        .add_i     (beat_take),
        .data_i    (s_data),
        .rd_idx_i  (scan_idx_q),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        scan_idx_d   = scan_idx_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        case (state_q)
            ACC: begin
                if (beat_take) begin
                    if (cnt_q == LAST_MEMBER) begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SCAN: begin
                // Best starts at index 0 / score 0, so strict '>' both keeps
                // the lowest index on ties and handles class 0 naturally.
                if (rd_data > best_score_q) begin
                    best_idx_d   = scan_idx_q;
                    best_score_d = rd_data;
                end
                if (scan_idx_q == LAST_CLASS) begin
                    scan_idx_d = '0;
                    state_d    = OUT;
                end else begin
                    scan_idx_d = scan_idx_q + CLS_W'(1);
                end
            end
            OUT: begin
                if (m_ready) begin
                    best_idx_d   = '0;
                    best_score_d = '0;
                    state_d      = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACC;
            cnt_q        <= '0;
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
        end
    end

endmodule

// File: tb/tb_ens_vote_acc.sv
module tb_ens_vote_acc;

    localparam int NE   = 4;
    localparam int NC   = 10;
    localparam int SW   = 4;
    localparam int SUMW = 6;
    localparam int CW   = 4;

    typedef logic [NC*SW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ens_vote_acc_if #(.NUM_ENS(NE), .NUM_CLASSES(NC), .SCORE_W(SW)) bus ();

    ens_vote_acc #(.NUM_ENS(NE), .NUM_CLASSES(NC), .SCORE_W(SW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (bus.s_valid),
        .s_ready (bus.s_ready),
        .s_data  (bus.s_data),
        .m_valid (bus.m_valid),
        .m_ready (bus.m_ready),
        .m_class (bus.m_class),
        .m_score (bus.m_score)
    );

    // Class cls gets hi, every other class gets lo.
    function automatic vec_t fill(input int cls, input int hi, input int lo);
        vec_t v;
        for (int k = 0; k < NC; k++) v[k*SW +: SW] = (k == cls) ? SW'(hi) : SW'(lo);
        return v;
    endfunction

    // Offer one beat and hold it until accepted; t_acc = cycle count after the accepting edge.
    task automatic send_beat(input vec_t d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        for (int i = 0; i < 100; i++) begin
            if (bus.s_ready === 1'b1) begin
                @(posedge clk);
                #1;
                t_acc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_beat: s_ready stayed 0 for 100 cycles, required 1");
        end
    endtask

    task automatic send_same(input vec_t d);
        for (int i = 0; i < NE; i++) send_beat(d);
    endtask

    // Waits for m_valid, captures outputs, holds for 'delay' cycles, then handshakes.
    task automatic get_result(input int delay, output bit seen, output int cls,
                              output int score, output int lat, output bit after_ok);
        seen = 1'b0; cls = -1; score = -1; lat = -1; after_ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.m_valid === 1'b1) begin seen = 1'b1; break; end
        end
        if (!seen) return;
        lat = cyc - t_acc;
        cls = int'(bus.m_class);
        score = int'(bus.m_score);
        for (int i = 0; i < delay; i++) @(negedge clk);
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        after_ok = (bus.m_valid === 1'b0) && (bus.s_ready === 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.m_class !== '0 || bus.m_score !== '0) begin
            n_bad++;
            $display("FAIL reset: s_ready=%b m_valid=%b class=%0d score=%0d, required 1 0 0 0",
                     bus.s_ready, bus.m_valid, bus.m_class, bus.m_score);
        end else $display("reset: outputs idle");
    endtask

    task automatic check_directed(input string name, input int ecls, input int esc,
                                  input bit chk_lat, input int delay);
        bit seen, after_ok; int cls, score, lat;
        get_result(delay, seen, cls, score, lat, after_ok);
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL %s timeout: m_valid=0 for 200 cycles, required 1", name); return;
        end
        if (chk_lat) begin
            n_cmp++;
            if (lat != NC) begin
                n_bad++; $display("FAIL %s latency: %0d edges after last beat, required %0d", name, lat, NC);
            end
        end
        n_cmp++;
        if (cls != ecls || score != esc) begin
            n_bad++; $display("FAIL %s result: class=%0d score=%0d, required class=%0d score=%0d",
                              name, cls, score, ecls, esc);
        end else $display("%s: class=%0d score=%0d", name, cls, score);
        n_cmp++;
        if (!after_ok) begin
            n_bad++; $display("FAIL %s release: m_valid/s_ready after handshake wrong, required 0/1", name);
        end
    endtask

    task automatic test_all_zero;
        send_same('0);
        check_directed("all_zero", 0, 0, 1'b1, 0);
    endtask

    task automatic test_class7;
        send_same(fill(7, 15, 3));
        check_directed("class7", 7, 60, 1'b1, 1);
    endtask

    task automatic test_tie;
        // class2: 15+15+5+5=40, class5: 4*10=40, class8: 4*9=36, others 4
        vec_t v;
        for (int m = 0; m < NE; m++) begin
            v = fill(0, 1, 1);
            v[2*SW +: SW] = (m < 2) ? 4'd15 : 4'd5;
            v[5*SW +: SW] = 4'd10;
            v[8*SW +: SW] = 4'd9;
            send_beat(v);
        end
        check_directed("tie_2_5", 2, 40, 1'b1, 0);
    endtask

    task automatic test_back_to_back;
        int hold_bad;
        send_same(fill(3, 10, 0));
        for (int i = 0; i < 200 && bus.m_valid !== 1'b1; i++) @(negedge clk);
        hold_bad = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = fill(9, 15, 15);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.m_valid !== 1'b1 || bus.m_class !== CW'(3) || bus.m_score !== SUMW'(40)
                || bus.s_ready !== 1'b0) begin
                n_bad++; hold_bad++;
                $display("FAIL stall cycle %0d: m_valid=%b class=%0d score=%0d s_ready=%b, required 1 3 40 0",
                         i, bus.m_valid, bus.m_class, bus.m_score, bus.s_ready);
            end
        end
        bus.s_valid = 1'b0;
        $display("stall: 20 held cycles, %0d bad", hold_bad);
        check_directed("stall_result", 3, 40, 1'b0, 0);
        send_same(fill(1, 2, 0));
        check_directed("after_stall", 1, 8, 1'b1, 0);
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.m_class !== '0 || bus.m_score !== '0) begin
            n_bad++;
            $display("FAIL %s: s_ready=%b m_valid=%b class=%0d score=%0d, required 1 0 0 0",
                     name, bus.s_ready, bus.m_valid, bus.m_class, bus.m_score);
        end else $display("%s: outputs idle", name);
    endtask

    task automatic test_reset_mid;
        // Mid-ACC: two partial beats discarded.
        send_beat(fill(4, 15, 0));
        send_beat(fill(4, 15, 0));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_idle("rst_mid_acc");
        send_same(fill(9, 1, 0));
        check_directed("after_rst_acc", 9, 4, 1'b1, 0);
        // Mid-SCAN, with a beat offered in the reset cycle (must be ignored).
        send_same(fill(6, 15, 0));
        repeat (3) @(negedge clk);
        rst = 1'b1; bus.s_valid = 1'b1; bus.s_data = fill(6, 15, 0);
        @(negedge clk); rst = 1'b0; bus.s_valid = 1'b0;
        check_idle("rst_mid_scan");
        send_same(fill(9, 1, 0));
        check_directed("after_rst_scan", 9, 4, 1'b1, 0);
        // During an OUT stall, with m_ready high in the reset cycle.
        send_same(fill(5, 7, 0));
        for (int i = 0; i < 200 && bus.m_valid !== 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b1; bus.m_ready = 1'b1;
        @(negedge clk); rst = 1'b0; bus.m_ready = 1'b0;
        check_idle("rst_in_out");
        send_same(fill(0, 1, 0));
        check_directed("after_rst_out", 0, 4, 1'b1, 0);
    endtask

    task automatic test_random;
        int sums[NC];
        int ecls, esc, rbad;
        bit seen, after_ok; int cls, score, lat;
        vec_t v;
        rbad = 0;
        for (int r = 0; r < 1000; r++) begin
            for (int k = 0; k < NC; k++) sums[k] = 0;
            for (int m = 0; m < NE; m++) begin
                for (int k = 0; k < NC; k++) begin
                    v[k*SW +: SW] = SW'($urandom_range(0, (r % 2 == 0) ? 15 : 3));
                    sums[k] += int'(v[k*SW +: SW]);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat(v);
            end
            ecls = 0; esc = sums[0];
            for (int k = 1; k < NC; k++) if (sums[k] > esc) begin ecls = k; esc = sums[k]; end
            get_result($urandom_range(0, 3), seen, cls, score, lat, after_ok);
            n_cmp++;
            if (!seen || cls != ecls || score != esc || lat != NC || !after_ok) begin
                n_bad++; rbad++;
                $display("FAIL random #%0d: seen=%b class=%0d score=%0d lat=%0d release=%b, required 1 %0d %0d %0d 1",
                         r, seen, cls, score, lat, after_ok, ecls, esc, NC);
            end
        end
        $display("random: 1000 results, %0d bad", rbad);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_zero();
        test_class7();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ens_vote_acc.md
ENS_VOTE_ACC -- requirements
Module: ens_vote_acc

Interface
REQ-001 The block SHALL have parameter NUM_ENS, default 4, meaning ensemble members combined per result (>=2).
REQ-002 The block SHALL have parameter NUM_CLASSES, default 10, meaning output classes per member.
REQ-003 The block SHALL have parameter SCORE_W, default 4, meaning unsigned per-class score width from each member's output layer.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port s_valid  input  1  upstream member score vector valid.
REQ-007 The block SHALL have port s_ready  output  1  block accepts a score vector this cycle.
REQ-008 The block SHALL have port s_data  input  NUM_CLASSES*SCORE_W  member scores; class k in bits [k*SCORE_W +: SCORE_W].
REQ-009 The block SHALL have port m_valid  output  1  result valid.
REQ-010 The block SHALL have port m_ready  input  1  downstream accepts result.
REQ-011 The block SHALL have port m_class  output  $clog2(NUM_CLASSES)  winning class index.
REQ-012 The block SHALL have port m_score  output  SUM_W  winning accumulated score, SUM_W = SCORE_W+$clog2(NUM_ENS).

Function
REQ-013 The block SHALL implement states ACC, SCAN, OUT; a transfer occurs only on a cycle where valid and ready are both high.
REQ-014 In ACC, s_ready SHALL be 1 and each accepted beat SHALL add every class score, zero-extended to SUM_W, into its class accumulator and increment a member counter.
REQ-015 Accumulation SHALL never overflow: SUM_W is sized for NUM_ENS maximal scores; no saturation logic.
REQ-016 On the beat that makes the member counter equal NUM_ENS, the block SHALL enter SCAN next cycle and clear the counter.
REQ-017 In SCAN, s_ready SHALL be 0 and the block SHALL compare one class per cycle, index 0 to NUM_CLASSES-1, keeping running best index and score; SCAN lasts exactly NUM_CLASSES cycles.
REQ-018 A class SHALL replace the running best only if strictly greater; ties resolve to the lowest index.
REQ-019 Latency: last member beat accepted at cycle t SHALL give m_valid=1 at cycle t+NUM_CLASSES+1, with m_class/m_score stable while m_valid is high.
REQ-020 In OUT, s_ready SHALL be 0; m_valid SHALL hold until m_ready; on the handshake cycle all accumulators and best registers SHALL clear and the state SHALL return to ACC, making s_ready 1 the following cycle.
REQ-021 m_valid SHALL be high only in OUT; m_ready is ignored outside OUT.
REQ-022 s_valid with s_ready=0 SHALL be ignored without side effects.

Reset
REQ-023 rst SHALL force state ACC, member counter 0, all accumulators 0, m_valid 0, m_class 0, m_score 0, s_ready 1 on the next edge, including mid-ACC, mid-SCAN or during OUT stall; partial results SHALL be discarded.
REQ-024 rst SHALL take priority over any handshake in the same cycle.

Structure
REQ-025 A shared package SHALL hold the state enum (ACC/SCAN/OUT) and the SUM_W width function; parameters stay on the module.
REQ-026 One sub-module, ens_class_acc_bank, SHALL hold the NUM_CLASSES accumulators with add/clear controls and an indexed read port for SCAN.

Verification
REQ-027 Scores all 0 for 4 members -> m_class=0, m_score=0 at t+11 after last beat.
REQ-028 Members give class 7 score 15, others 3 -> m_class=7, m_score=60.
REQ-029 Class 2 and class 5 both total 40, others lower -> m_class=2 (tie to lowest).
REQ-030 Result held with m_ready=0 for 20 cycles while s_valid=1 -> m_valid, m_class stable, s_ready=0, no beat accepted; after m_ready pulse, next 4 beats yield a fresh result uncontaminated by prior sums.
REQ-031 rst asserted after 2 of 4 beats, then 4 new beats with class 9 score 1, others 0 -> m_class=9, m_score=4.
REQ-032 Random s_valid/m_ready gaps over 1000 results -> every result matches a reference model sum-and-argmax.
